mdu_sequencer: RTL and testbench
================================

// Module: mdu_sequencer
// PURPOSE
//  Iterative multiply/divide sequencer sharing one shift-add/restoring-subtract datapath.
//  Sits beside the execute-stage ALU: accepts one M-extension op from E, holds the pipeline
//  via stallE for the iteration count, then presents the result for one cycle in E.
//  Radix-2, one result bit per cycle; one op in flight at a time.
// PARAMETERS
//  XLEN     32  operand/result width (= `WORD)
//  CNT_W     6  iteration counter width, >= clog2(XLEN)+1
// PORTS
//  clk      in   1     clock, all state updates on rising edge
//  reset    in   1     asynchronous, active-low (0 = reset), clears all state immediately
//  startE   in   1     E holds a valid MDU op (validE & mdu decode); level, held while stalled
//  opE      in   3     000 MUL,001 MULH,011 MULHU,100 DIV,101 DIVU,110 REM,111 REMU,010 rsvd
//  src1E    in   XLEN  operand A (forwarded value, from ALU input select)
//  src2E    in   XLEN  operand B (forwarded value)
//  flushE   in   1     kill the op in E (branch redirect); aborts any op in progress
//  stallE   out  1     hold F/D/E registers; E instruction is not retired
//  busy     out  1     state != IDLE
//  doneE    out  1     1-cycle pulse: resultE valid, E instruction may advance
//  resultE  out  XLEN  MUL/MULH*: product word; DIV*: quotient; REM*: remainder
// BEHAVIOUR
//  Reset: state=IDLE, count=0, acc/quot/rem/result regs=0; stallE=0, busy=0, doneE=0, resultE=0.
//  States: IDLE, RUN, DONE.
//  IDLE: startE & !flushE -> latch op, |operands| (signed ops: negate negatives), sign of
//   result, count=XLEN; go RUN. stallE=1 combinationally in this same cycle.
//   Shortcuts (go DONE directly, 1 cycle): divide by 0 -> quot=all-ones, rem=src1E;
//   signed DIV/REM with src1E=0x80000000, src2E=0xFFFFFFFF -> quot=0x80000000, rem=0;
//   op 010 -> result 0.
//  RUN: one iteration/cycle, count decrements; count reaches 0 -> DONE. stallE=1.
//   MUL: 2*XLEN accumulator, shift-add on multiplier LSB. MUL takes low word; MULH/MULHU high.
//   DIV/REM: restoring, shift dividend MSB into rem, subtract if rem>=divisor, set quot bit.
//   Sign fixup applied on RUN->DONE: product negated if signs differ (MULH);
//   quot negated if signs differ; rem takes the sign of the dividend.
//  DONE: doneE=1, stallE=0, resultE valid for exactly this cycle; -> IDLE unconditionally.
//   startE seen in DONE is the same instruction and is ignored.
//  Latency: start sampled at cycle T -> doneE at T+XLEN+1 (T+33 @32); shortcut -> T+1.
//   Back-to-back ops: next op's start no earlier than T+XLEN+2.
//  flushE: in IDLE blocks start; in RUN -> IDLE next edge, no doneE, stallE=0 in that cycle;
//   in DONE, doneE still pulses (pipeline discards it). flushE has priority over startE.
//  reset deasserted mid-op: op lost, no doneE; restart requires fresh startE.
//  resultE holds last value outside DONE; consumers qualify with doneE.
//  Operand values are sampled only on IDLE->RUN; later changes on src*E are ignored.
// TESTING
//  MUL 7 * 0xFFFFFFFD at T -> stallE T..T+32, doneE at T+33, resultE=0xFFFFFFEB.
//  MULH 0x80000000*0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE.
//  DIV 100/7 -> 14; REM 0xFFFFFF9C(-100)/7 -> 0xFFFFFFFE(-2); DIVU 0xFFFFFFFF/2 -> 0x7FFFFFFF.
//  DIV x/0 -> 0xFFFFFFFF, REM 5/0 -> 5, DIV 0x80000000/-1 -> 0x80000000: all doneE at T+1.
//  MUL started at T, flushE at T+10 -> busy=0 and stallE=0 from T+11, no doneE; new DIV
//   start at T+12 completes normally at T+45.
//  reset pulled low at T+5 of a DIV -> all outputs 0 immediately; no doneE after release.

Source files
------------

// File: rtl/mdu_sequencer.sv
// Iterative radix-2 multiply/divide unit for the execute stage.
// One shared shift-add / restoring-subtract step per cycle, one op in flight.
module mdu_sequencer #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            startE,
  input  logic [2:0]      opE,
  input  logic [XLEN-1:0] src1E,
  input  logic [XLEN-1:0] src2E,
  input  logic            flushE,
  output logic            stallE,
  output logic            busy,
  output logic            doneE,
  output logic [XLEN-1:0] resultE,
  output logic [1:0]      state_dbg
);

  // Handshake: startE is a level held by E while stallE=1. An accepted op
  // raises stallE in the accept cycle and throughout RUN; doneE pulses for one
  // cycle with stallE=0, and that cycle's startE is the same instruction.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [2:0] OP_MUL   = 3'b000;
  localparam logic [2:0] OP_MULH  = 3'b001;
  localparam logic [2:0] OP_RSVD  = 3'b010;
  localparam logic [2:0] OP_MULHU = 3'b011;
  localparam logic [2:0] OP_DIV   = 3'b100;
  localparam logic [2:0] OP_DIVU  = 3'b101;
  localparam logic [2:0] OP_REM   = 3'b110;
  localparam logic [2:0] OP_REMU  = 3'b111;

  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  state_t              state_q, state_d;
  logic [2:0]          op_q, op_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [2*XLEN-1:0]   acc_q, acc_d;
  logic [XLEN-1:0]     opb_q, opb_d;
  logic                neg_q, neg_d;
  logic                dneg_q, dneg_d;
  logic [XLEN-1:0]     result_q, result_d;

  logic                stall_c;
  logic                is_div, is_rem, signed_op;
  logic                a_neg, b_neg;
  logic [XLEN-1:0]     a_mag, b_mag;
  logic [XLEN:0]       add_hi;
  logic [2*XLEN-1:0]   mul_next;
  logic [XLEN:0]       r_sh;
  logic [XLEN:0]       diff;
  logic                ge;
  logic [2*XLEN-1:0]   div_next;
  logic [2*XLEN-1:0]   iter_next;
  logic [2*XLEN-1:0]   prod;
  logic [XLEN-1:0]     quot, rem;
  logic [XLEN-1:0]     fin;

  // Operand decode for the op currently presented by E.
  always_comb begin
    is_div    = opE[2];
    is_rem    = opE[2] & opE[1];
    signed_op = (opE == OP_MULH) || (opE == OP_DIV) || (opE == OP_REM);
    a_neg     = signed_op & src1E[XLEN-1];
    b_neg     = signed_op & src2E[XLEN-1];
    a_mag     = a_neg ? -src1E : src1E;
    b_mag     = b_neg ? -src2E : src2E;
  end

  // acc holds {partial product, multiplier} for MUL, {remainder, dividend/quotient} for DIV.
  always_comb begin
    add_hi   = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, opb_q};
    mul_next = acc_q[0] ? {add_hi, acc_q[XLEN-1:1]} : {1'b0, acc_q[2*XLEN-1:1]};
    r_sh     = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    diff     = r_sh - {1'b0, opb_q};
    ge       = (r_sh >= {1'b0, opb_q});
    div_next = ge ? {diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1}
                  : {r_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
    iter_next = op_q[2] ? div_next : mul_next;
  end

  // Sign fixup on the final iteration result.
  always_comb begin
    prod = neg_q ? -iter_next : iter_next;
    quot = iter_next[XLEN-1:0];
    rem  = iter_next[2*XLEN-1:XLEN];
    case (op_q)
      OP_MUL:            fin = prod[XLEN-1:0];
      OP_MULH, OP_MULHU: fin = prod[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:   fin = neg_q ? -quot : quot;
      OP_REM, OP_REMU:   fin = dneg_q ? -rem : rem;
      default:           fin = '0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opb_d    = opb_q;
    neg_d    = neg_q;
    dneg_d   = dneg_q;
    result_d = result_q;
    stall_c  = 1'b0;
    doneE    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (startE && !flushE) begin
          stall_c = 1'b1;
          op_d    = opE;
          cnt_d   = CNT_W'(XLEN);
          if (opE == OP_RSVD) begin
            result_d = '0;
            state_d  = S_DONE;
          end else if (is_div && (src2E == '0)) begin
            result_d = is_rem ? src1E : '1;
            state_d  = S_DONE;
          end else if (is_div && !opE[0] && (src1E == MIN_NEG) && (src2E == '1)) begin
            result_d = is_rem ? '0 : MIN_NEG;
            state_d  = S_DONE;
          end else begin
            acc_d   = {{XLEN{1'b0}}, a_mag};
            opb_d   = b_mag;
            neg_d   = a_neg ^ b_neg;
            dneg_d  = a_neg;
            state_d = S_RUN;
          end
        end
      end
      S_RUN: begin
        if (flushE) begin
          state_d = S_IDLE;
        end else begin
          stall_c = 1'b1;
          acc_d   = iter_next;
          cnt_d   = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            result_d = fin;
            state_d  = S_DONE;
          end
        end
      end
      S_DONE: begin
        doneE   = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      cnt_q    <= '0;
      acc_q    <= '0;
      opb_q    <= '0;
      neg_q    <= 1'b0;
      dneg_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opb_q    <= opb_d;
      neg_q    <= neg_d;
      dneg_q   <= dneg_d;
      result_q <= result_d;
    end
  end

  // The accept-cycle stall is combinational from startE, so it is masked while reset is low.
  assign stallE    = stall_c & reset;
  assign busy      = (state_q != S_IDLE);
  assign resultE   = result_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_mdu_sequencer.sv
// Directed testbench for mdu_sequencer: latency, results, shortcuts, flush and reset.
module tb_mdu_sequencer;

  logic        clk;
  logic        reset;
  logic        startE;
  logic [2:0]  opE;
  logic [31:0] src1E;
  logic [31:0] src2E;
  logic        flushE;
  logic        stallE;
  logic        busy;
  logic        doneE;
  logic [31:0] resultE;
  logic [1:0]  state_dbg;

  int checks = 0;
  int errors = 0;

  mdu_sequencer #(.XLEN(32), .CNT_W(6)) dut (
    .clk       (clk),
    .reset     (reset),
    .startE    (startE),
    .opE       (opE),
    .src1E     (src1E),
    .src2E     (src2E),
    .flushE    (flushE),
    .stallE    (stallE),
    .busy      (busy),
    .doneE     (doneE),
    .resultE   (resultE),
    .state_dbg (state_dbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Start an op in the next cycle and follow it to doneE, scrambling operands after accept.
  task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
    int  n;
    bit  seen;
    @(negedge clk);
    opE = op; src1E = a; src2E = b; startE = 1'b1; flushE = 1'b0;
    #1;
    checks++;
    if (stallE !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_accept: stallE=%b busy=%b, required stallE=1 busy=0", name, stallE, busy);
    end
    n = 0;
    seen = 1'b0;
    while (!seen && n < 40) begin
      @(negedge clk);
      #1;
      n++;
      if (doneE === 1'b1) begin
        seen = 1'b1;
      end else begin
        checks++;
        if (stallE !== 1'b1) begin
          errors++;
          $display("FAIL %s_stall: cycle %0d stallE=%b, required 1", name, n, stallE);
        end
      end
      src1E = $urandom;
      src2E = $urandom;
    end
    checks++;
    if (!seen || n != exp_lat) begin
      errors++;
      $display("FAIL %s_latency: doneE seen=%0d after %0d cycles, required %0d", name, seen, n, exp_lat);
    end
    checks++;
    if (resultE !== exp) begin
      errors++;
      $display("FAIL %s_result: resultE=%h, required %h", name, resultE, exp);
    end
    checks++;
    if (stallE !== 1'b0) begin
      errors++;
      $display("FAIL %s_done_stall: stallE=%b, required 0", name, stallE);
    end
    startE = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; startE = 1'b1; flushE = 1'b0; opE = 3'b100;
    src1E = 32'd100; src2E = 32'd7;
    #1;
    checks++;
    if ({stallE, busy, doneE} !== 3'b000 || resultE !== 32'h0 || state_dbg !== 2'd0) begin
      errors++;
      $display("FAIL reset_outputs: stall=%b busy=%b done=%b result=%h state=%0d, required all 0",
               stallE, busy, doneE, resultE, state_dbg);
    end
    @(negedge clk);
    @(negedge clk);
    startE = 1'b0;
    reset = 1'b1;
  endtask

  task automatic test_mul();
    run_op("mul",   3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 33);
    run_op("mulh",  3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 33);
    run_op("mulhu", 3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33);
    run_op("mulh_neg", 3'b001, 32'hFFFFFFFF, 32'd5,     32'hFFFFFFFF, 33);
  endtask

  task automatic test_div();
    run_op("div",      3'b100, 32'd100,      32'd7,  32'd14,       33);
    run_op("rem_neg",  3'b110, 32'hFFFFFF9C, 32'd7,  32'hFFFFFFFE, 33);
    run_op("divu",     3'b101, 32'hFFFFFFFF, 32'd2,  32'h7FFFFFFF, 33);
    run_op("div_neg",  3'b100, 32'hFFFFFF9C, 32'd7,  32'hFFFFFFF2, 33);
    run_op("remu",     3'b111, 32'd100,      32'd7,  32'd2,        33);
  endtask

  task automatic test_shortcuts();
    run_op("div_by0",  3'b100, 32'h00001234, 32'h0,        32'hFFFFFFFF, 1);
    run_op("rem_by0",  3'b110, 32'd5,        32'h0,        32'd5,        1);
    run_op("div_ovf",  3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
    run_op("rem_ovf",  3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h0,        1);
    run_op("rsvd",     3'b010, 32'd9,        32'd9,        32'h0,        1);
  endtask

  task automatic test_flush_run();
    @(negedge clk);
    opE = 3'b000; src1E = 32'd3; src2E = 32'd4; startE = 1'b1; flushE = 1'b0;
    for (int i = 1; i <= 10; i++) @(negedge clk);
    flushE = 1'b1;
    #1;
    checks++;
    if (stallE !== 1'b0 || doneE !== 1'b0) begin
      errors++;
      $display("FAIL flush_run_stall: stallE=%b doneE=%b, required 0 0", stallE, doneE);
    end
    @(negedge clk);
    flushE = 1'b0; startE = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || stallE !== 1'b0 || doneE !== 1'b0) begin
      errors++;
      $display("FAIL flush_run_idle: busy=%b stallE=%b doneE=%b, required 0 0 0", busy, stallE, doneE);
    end
    run_op("div_after_flush", 3'b100, 32'd100, 32'd7, 32'd14, 33);
  endtask

  task automatic test_flush_idle();
    @(negedge clk);
    opE = 3'b100; src1E = 32'd8; src2E = 32'd0; startE = 1'b1; flushE = 1'b1;
    #1;
    checks++;
    if (stallE !== 1'b0) begin
      errors++;
      $display("FAIL flush_idle_stall: stallE=%b, required 0", stallE);
    end
    @(negedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || doneE !== 1'b0) begin
      errors++;
      $display("FAIL flush_idle_busy: busy=%b doneE=%b, required 0 0", busy, doneE);
    end
    startE = 1'b0; flushE = 1'b0;
  endtask

  task automatic test_flush_done();
    @(negedge clk);
    opE = 3'b101; src1E = 32'd9; src2E = 32'd0; startE = 1'b1; flushE = 1'b0;
    @(negedge clk);
    flushE = 1'b1;
    #1;
    checks++;
    if (doneE !== 1'b1 || resultE !== 32'hFFFFFFFF) begin
      errors++;
      $display("FAIL flush_done_pulse: doneE=%b resultE=%h, required 1 ffffffff", doneE, resultE);
    end
    startE = 1'b0; flushE = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || doneE !== 1'b0) begin
      errors++;
      $display("FAIL flush_done_idle: busy=%b doneE=%b, required 0 0", busy, doneE);
    end
  endtask

  task automatic test_reset_midop();
    int dones;
    @(negedge clk);
    opE = 3'b100; src1E = 32'd100; src2E = 32'd7; startE = 1'b1; flushE = 1'b0;
    for (int i = 1; i <= 5; i++) @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if ({stallE, busy, doneE} !== 3'b000 || resultE !== 32'h0) begin
      errors++;
      $display("FAIL reset_midop_outputs: stall=%b busy=%b done=%b result=%h, required all 0",
               stallE, busy, doneE, resultE);
    end
    startE = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (doneE === 1'b1 || busy === 1'b1) dones++;
    end
    checks++;
    if (dones != 0) begin
      errors++;
      $display("FAIL reset_midop_nodone: %0d cycles with doneE/busy high, required 0", dones);
    end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_shortcuts();
    test_flush_run();
    test_flush_idle();
    test_flush_done();
    test_reset_midop();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
